// File: rtl/sram_arb_pkg.sv
// Shared owner tags, FSM encodings and request payload type for the SRAM-like port arbiter.
package sram_arb_pkg;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  localparam int unsigned OUTSTANDING_DEFAULT = 4;

  // Everything a master must hold stable until addr_ok, muxed as one unit.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  function automatic sram_req_t pack_req(input logic wr, input logic [1:0] size,
                                         input logic [3:0] wstrb, input logic [31:0] addr,
                                         input logic [31:0] wdata);
    sram_req_t r;
    r.wr    = wr;
    r.size  = size;
    r.wstrb = wstrb;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/sram_arb_tagfifo.sv
// 1-bit-wide synchronous FIFO holding the owner tag of every accepted, uncompleted request.
module sram_arb_tagfifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o,
  output logic             head_o
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      // Power-of-two depth: pointer overflow is the modulo wrap.
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like slave between instruction (i) and data (d) masters with in-order responses.
// Build option SRAM_ARB_RR_EN: round-robin grant in IDLE instead of fixed d-over-i priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING = OUTSTANDING_DEFAULT,
  localparam int unsigned PTR_W = $clog2(OUTSTANDING)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_req,
  input  logic           i_wr,
  input  logic [1:0]     i_size,
  input  logic [3:0]     i_wstrb,
  input  logic [31:0]    i_addr,
  input  logic [31:0]    i_wdata,
  output logic           i_addr_ok,
  output logic           i_data_ok,
  output logic [31:0]    i_rdata,
  input  logic           d_req,
  input  logic           d_wr,
  input  logic [1:0]     d_size,
  input  logic [3:0]     d_wstrb,
  input  logic [31:0]    d_addr,
  input  logic [31:0]    d_wdata,
  output logic           d_addr_ok,
  output logic           d_data_ok,
  output logic [31:0]    d_rdata,
  output logic           s_req,
  output logic           s_wr,
  output logic [1:0]     s_size,
  output logic [3:0]     s_wstrb,
  output logic [31:0]    s_addr,
  output logic [31:0]    s_wdata,
  input  logic           s_addr_ok,
  input  logic           s_data_ok,
  input  logic [31:0]    s_rdata,
  output logic [PTR_W:0] outstanding_cnt,
  output logic           err_unexp
);

  logic      state_q, state_d;
  logic      owner_q, owner_d;
  logic      err_q, err_d;
  logic      grant;
  logic      sel_req;
  logic      accept;
  logic      pop_valid;
  logic      fifo_full, fifo_empty, fifo_head;
  sram_req_t i_pl, d_pl, s_pl;

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;
`endif

  assign i_pl = pack_req(i_wr, i_size, i_wstrb, i_addr, i_wdata);
  assign d_pl = pack_req(d_wr, d_size, d_wstrb, d_addr, d_wdata);

  always_comb begin
    grant = OWNER_I;
    if (state_q == ST_HOLD) begin
      grant = owner_q;
    end else begin
`ifdef SRAM_ARB_RR_EN
      if (i_req && d_req) begin
        grant = (last_q == OWNER_D) ? OWNER_I : OWNER_D;
      end else if (d_req) begin
        grant = OWNER_D;
      end else begin
        grant = OWNER_I;
      end
`else
      grant = d_req ? OWNER_D : OWNER_I;
`endif
    end
  end

  assign sel_req = (grant == OWNER_D) ? d_req : i_req;
  assign s_pl    = (grant == OWNER_D) ? d_pl : i_pl;

  // Full uses the registered count, so a same-cycle pop never frees a slot early.
  assign s_req   = !reset && !fifo_full && sel_req;
  assign s_wr    = s_pl.wr;
  assign s_size  = s_pl.size;
  assign s_wstrb = s_pl.wstrb;
  assign s_addr  = s_pl.addr;
  assign s_wdata = s_pl.wdata;

  assign accept    = s_req && s_addr_ok;
  assign i_addr_ok = accept && (grant == OWNER_I);
  assign d_addr_ok = accept && (grant == OWNER_D);

  assign pop_valid = !reset && s_data_ok && !fifo_empty;
  assign i_data_ok = pop_valid && (fifo_head == OWNER_I);
  assign d_data_ok = pop_valid && (fifo_head == OWNER_D);
  assign i_rdata   = s_rdata;
  assign d_rdata   = s_rdata;

  assign err_d     = err_q || (s_data_ok && fifo_empty);
  assign err_unexp = err_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_req && !s_addr_ok) begin
          state_d = ST_HOLD;
          owner_d = grant;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SRAM_ARB_RR_EN
  assign last_d = accept ? grant : last_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_I;
      err_q   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_q  <= OWNER_I;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
`ifdef SRAM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  sram_arb_tagfifo #(
    .DEPTH (OUTSTANDING)
  ) u_tagfifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (accept),
    .din_i   (grant),
    .pop_i   (pop_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_cnt),
    .head_o  (fifo_head)
  );

endmodule
